// File: rtl/f_pc_fetch.sv
// Fetch-stage PC unit: selects the next PC and runs the request/grant/response handshake with instruction memory.
// Redirects during an in-flight fetch are buffered in pend and the stale response is dropped.
module f_pc_fetch #(
    parameter int unsigned           WIDTH      = 32,
    parameter logic [WIDTH-1:0]      RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0]      HANDLER_PC = 32'h0000_4180,
    parameter logic [WIDTH-1:0]      TEXT_BASE  = 32'h0000_3000,
    parameter logic [WIDTH-1:0]      TEXT_END   = 32'h0000_6ffc
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_en,
    input  logic             req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             f_valid,
    output logic [WIDTH-1:0] f_pc,
    output logic [WIDTH-1:0] f_instr,
    output logic             f_exc_adel
);

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pc, pc_n;
    logic [WIDTH-1:0] pend, pend_n;
    logic             kill, kill_n;
    logic             fv_n, fexc_n;
    logic [WIDTH-1:0] fpc_n, finstr_n;

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             bad;
    logic [WIDTH-1:0] pc_plus4;

    assign redirect = req | eret | br_taken;
    assign target   = req  ? HANDLER_PC :
                      eret ? epc        : br_target;
    assign bad      = (pc[1:0] != 2'b00) | (pc < TEXT_BASE) | (pc > TEXT_END);
    assign pc_plus4 = pc + WIDTH'(4);

    assign imem_req  = (state == S_ISSUE) & ~bad & ~reset;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_ISSUE;
            pc         <= RESET_PC;
            pend       <= '0;
            kill       <= 1'b0;
            f_valid    <= 1'b0;
            f_pc       <= '0;
            f_instr    <= '0;
            f_exc_adel <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend       <= pend_n;
            kill       <= kill_n;
            f_valid    <= fv_n;
            f_pc       <= fpc_n;
            f_instr    <= finstr_n;
            f_exc_adel <= fexc_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        pend_n   = pend;
        kill_n   = kill;
        fv_n     = f_valid;
        fpc_n    = f_pc;
        finstr_n = f_instr;
        fexc_n   = f_exc_adel;

        case (state)
            S_ISSUE: begin
                fv_n = 1'b0;
                // A redirect supersedes both an ungranted request and a faulting PC.
                if (redirect && (bad || !imem_gnt)) begin
                    pc_n = target;
                end else if (bad) begin
                    state_n  = S_DONE;
                    fv_n     = 1'b1;
                    fpc_n    = pc;
                    finstr_n = '0;
                    fexc_n   = 1'b1;
                end else if (imem_gnt) begin
                    state_n = S_WAIT;
                    if (redirect) begin
                        kill_n = 1'b1;
                        pend_n = target;
                    end
                end
            end

            S_WAIT: begin
                fv_n = 1'b0;
                if (imem_rvalid) begin
                    if (kill || redirect) begin
                        pc_n    = redirect ? target : pend;
                        kill_n  = 1'b0;
                        state_n = S_ISSUE;
                    end else begin
                        state_n  = S_DONE;
                        fv_n     = 1'b1;
                        fpc_n    = pc;
                        finstr_n = imem_rdata;
                        fexc_n   = 1'b0;
                    end
                end else if (redirect) begin
                    kill_n = 1'b1;
                    pend_n = target;
                end
            end

            S_DONE: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = S_ISSUE;
                    fv_n    = 1'b0;
                    fexc_n  = 1'b0;
                end else if (pc_en) begin
                    pc_n    = pc_plus4;
                    state_n = S_ISSUE;
                    fv_n    = 1'b0;
                    fexc_n  = 1'b0;
                end
            end

            default: begin
                state_n = S_ISSUE;
            end
        endcase
    end

endmodule
